// File: rtl/upcount_arbiter.sv
// Round-robin arbiter that shares one external upcount timer among NREQ requesters.
// The granted requester gets the counter cleared, enabled for len cycles, then a done pulse.
module upcount_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_Resetn,
  output logic              cnt_E,
  input  logic [W-1:0]      cnt_Q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [W-1:0]    target_q, target_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic found;
  int   sel;
  int   idx;
  logic abandon;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      target_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    found    = 1'b0;
    sel      = 0;
    idx      = 0;
    // Search starts at the pointer so the last winner goes to the back of the line.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    abandon = ((req & grant_q) == '0);

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = NREQ'(1) << sel;
          target_d = len[sel*W +: W];
          ptr_d    = PW'((sel + 1) % NREQ);
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (abandon) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (target_q != '0) begin
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        if (abandon) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (cnt_Q == target_q - W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant      = grant_q;
    done       = (state_q == DONE) ? grant_q : '0;
    busy       = (state_q != IDLE);
    cnt_E      = (state_q == RUN);
    cnt_Resetn = Resetn & (state_q != CLEAR);
  end

endmodule

// File: tb/tb_upcount_arbiter.sv
// Bench for upcount_arbiter: models the attached upcount and a job-timeline reference model,
// then runs directed scenarios and a randomized run against it.
module tb_upcount_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           Clock = 1'b0;
  logic           Resetn;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic           cnt_Resetn;
  logic           cnt_E;
  logic [W-1:0]   cnt_Q = '0;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: granted index (-1 idle), cycles since grant, latched target, pointer, counter.
  int m_g = -1;
  int m_c = 0;
  int m_tgt = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  upcount_arbiter #(.NREQ(N), .W(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .len(len),
    .grant(grant), .done(done), .busy(busy),
    .cnt_Resetn(cnt_Resetn), .cnt_E(cnt_E), .cnt_Q(cnt_Q)
  );

  always #2 Clock = ~Clock;

  always @(posedge Clock) begin
    if (!cnt_Resetn) cnt_Q <= '0;
    else if (cnt_E)  cnt_Q <= cnt_Q + 1'b1;
  end

  function automatic logic [2*N+3+W-1:0] exp_vec();
    logic [N-1:0] g;
    logic [N-1:0] dn;
    logic b, en, rn;
    g  = (m_g >= 0) ? (N'(1) << m_g) : '0;
    b  = (m_g >= 0);
    en = (m_g >= 0) && (m_c >= 1) && (m_c <= m_tgt);
    dn = ((m_g >= 0) && (m_c == m_tgt + 1)) ? g : '0;
    rn = Resetn && !((m_g >= 0) && (m_c == 0));
    return {g, dn, b, en, rn, W'(m_cnt)};
  endfunction

  function automatic logic [2*N+3+W-1:0] obs_vec();
    return {grant, done, busy, cnt_E, cnt_Resetn, cnt_Q};
  endfunction

  task automatic step();
    logic [N-1:0]   r;
    logic [N*W-1:0] l;
    logic           rs;
    logic           pre_rn, pre_en, found;
    int             i;
    r = req; l = len; rs = Resetn;
    pre_rn = rs && !((m_g >= 0) && (m_c == 0));
    pre_en = (m_g >= 0) && (m_c >= 1) && (m_c <= m_tgt);
    @(posedge Clock);
    if (!pre_rn)     m_cnt = 0;
    else if (pre_en) m_cnt = (m_cnt + 1) % (1 << W);
    if (!rs) begin
      m_g = -1; m_c = 0; m_ptr = 0; m_tgt = 0;
    end else if (m_g < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && r[i]) begin
          found = 1'b1;
          m_g = i; m_c = 0; m_tgt = int'(l[i*W +: W]); m_ptr = (i + 1) % N;
        end
      end
    end else if (m_c <= m_tgt && !r[m_g]) begin
      m_g = -1;
    end else if (m_c == m_tgt + 1) begin
      m_g = -1;
    end else begin
      m_c++;
    end
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; req = '1; len = {N{4'd3}};
    for (int k = 0; k < 2; k++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if ({grant, done, busy, cnt_E, cnt_Resetn} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero", {grant, done, busy, cnt_E, cnt_Resetn});
    end
    Resetn = 1'b1;
    step();
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_grant: got %b expected 0001", grant);
    end
    req = '0;
    step();
    tests_run++;
    if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_abandon: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int  en_cnt, dn_cnt;
    bit  fin;
    en_cnt = 0; dn_cnt = 0; fin = 0;
    req = 4'b0010; len = {4'd7, 4'd9, 4'd5, 4'd3};
    step();
    tests_run++;
    if (grant !== 4'b0010 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int k = 0; k < 20 && !fin; k++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL single_cycle: got %h expected %h", obs_vec(), exp_vec());
      end
      if (cnt_E === 1'b1) en_cnt++;
      if (done !== '0) begin
        dn_cnt++;
        fin = 1;
        tests_run++;
        if (done !== 4'b0010 || cnt_Q !== 4'd5) begin
          tests_failed++;
          $display("[TB] FAIL single_done: got done=%b cnt_Q=%0d expected done=0010 cnt_Q=5", done, cnt_Q);
        end
        req = '0;
        step();
        tests_run++;
        if (busy !== 1'b0 || obs_vec() !== exp_vec()) begin
          tests_failed++;
          $display("[TB] FAIL single_busy_drop: got %h expected %h", obs_vec(), exp_vec());
        end
      end
    end
    req = '0;
    tests_run++;
    if (en_cnt != 5 || dn_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_counts: got en=%0d done=%0d expected en=5 done=1", en_cnt, dn_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] prev, g;
    logic [N-1:0] seq[$];
    int           lens[$];
    int           gaps[$];
    logic [N-1:0] exp_seq [5];
    int           run, dn_cnt;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Resetn = 1'b0; req = '0;
    step(); step();
    Resetn = 1'b1; req = '1; len = {N{4'd2}};
    prev = '0; run = 0; dn_cnt = 0;
    for (int k = 0; k < 26; k++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL rr_cycle: got %h expected %h", obs_vec(), exp_vec());
      end
      if (done !== '0) dn_cnt++;
      g = grant;
      if (g !== prev) begin
        if (prev !== '0) lens.push_back(run);
        else if (seq.size() > 0) gaps.push_back(run);
        if (g !== '0) seq.push_back(g);
        run = 1;
      end else begin
        run++;
      end
      prev = g;
    end
    req = '0;
    step();
    tests_run++;
    if (seq.size() < 5 || lens.size() < 4 || gaps.size() < 4) begin
      tests_failed++;
      $display("[TB] FAIL rr_segments: got %0d grants expected at least 5", seq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (seq[k] !== exp_seq[k]) begin
          tests_failed++;
          $display("[TB] FAIL rr_order[%0d]: got %b expected %b", k, seq[k], exp_seq[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (lens[k] != 4 || gaps[k] != 1) begin
          tests_failed++;
          $display("[TB] FAIL rr_timing[%0d]: got len=%0d gap=%0d expected len=4 gap=1", k, lens[k], gaps[k]);
        end
      end
    end
    tests_run++;
    if (dn_cnt != 5) begin
      tests_failed++;
      $display("[TB] FAIL rr_done_count: got %0d expected 5", dn_cnt);
    end
  endtask

  task automatic test_boundary();
    int en_cnt;
    bit fin;
    req = 4'b0100; len = {4'd1, 4'd0, 4'd1, 4'd1};
    step();
    tests_run++;
    if (grant !== 4'b0100 || cnt_E !== 1'b0 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL len0_grant: got %h expected %h", obs_vec(), exp_vec());
    end
    step();
    tests_run++;
    if (done !== 4'b0100 || cnt_E !== 1'b0 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL len0_done: got %h expected %h", obs_vec(), exp_vec());
    end
    req = '0;
    step();
    req = 4'b1000; len = {4'd15, 4'd2, 4'd2, 4'd2};
    en_cnt = 0; fin = 0;
    for (int k = 0; k < 25 && !fin; k++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL len15_cycle: got %h expected %h", obs_vec(), exp_vec());
      end
      if (cnt_E === 1'b1) en_cnt++;
      if (done !== '0) fin = 1;
    end
    req = '0;
    step();
    tests_run++;
    if (!fin || en_cnt != 15 || cnt_Q !== 4'd15) begin
      tests_failed++;
      $display("[TB] FAIL len15_result: got done_seen=%0d en=%0d cnt_Q=%0d expected 1 15 15", fin, en_cnt, cnt_Q);
    end
  endtask

  task automatic test_abandon();
    int en_cnt;
    bit fin;
    req = 4'b0001; len = {4'd1, 4'd1, 4'd1, 4'd10};
    en_cnt = 0; fin = 0;
    for (int k = 0; k < 10 && !fin; k++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL abandon_run: got %h expected %h", obs_vec(), exp_vec());
      end
      if (cnt_E === 1'b1) en_cnt++;
      if (en_cnt == 3) fin = 1;
    end
    req = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      tests_run++;
      if ({grant, done, cnt_E} !== '0 || cnt_Q !== 4'd3 || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL abandon_hold: got %h cnt_Q=%0d expected %h cnt_Q=3", obs_vec(), cnt_Q, exp_vec());
      end
    end
    req = 4'b0011;
    step();
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL abandon_next_grant: got %b expected 0010", grant);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    int en_cnt;
    bit fin;
    req = 4'b0010; len = {4'd1, 4'd1, 4'd8, 4'd1};
    en_cnt = 0; fin = 0;
    for (int k = 0; k < 10 && !fin; k++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL midreset_run: got %h expected %h", obs_vec(), exp_vec());
      end
      if (cnt_E === 1'b1) en_cnt++;
      if (en_cnt == 4) fin = 1;
    end
    Resetn = 1'b0; req = 4'b1010;
    step();
    tests_run++;
    if ({grant, done, busy, cnt_E, cnt_Resetn} !== '0 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL midreset_abort: got %h expected %h", obs_vec(), exp_vec());
    end
    Resetn = 1'b1;
    step();
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL midreset_next_grant: got %b expected 0010", grant);
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      Resetn = ($urandom_range(0, 79) != 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      for (int b = 0; b < N; b++)
        len[b*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 5));
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    Resetn = 1'b0; req = '0; len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
